// File: rtl/uart_matrix_rx_parser.sv
// Parses a received byte stream (rows, cols, row-major elements) into matrix
// storage write beats, allocating slots round-robin and flagging bad frames.
module uart_matrix_rx_parser #(
   parameter int DATA_WIDTH     = 8,
   parameter int MAX_SIZE       = 5,
   parameter int MATRIX_NUM     = 8,
   parameter int MAX_VALUE      = 9,
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int MATRIX_IDX_W   = 3,
   parameter int ADDR_IN_W      = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_valid,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   output logic                    matrix_wr_en,
   output logic [MATRIX_IDX_W-1:0] matrix_idx,
   output logic [2:0]              store_row,
   output logic [2:0]              store_col,
   output logic [ADDR_IN_W-1:0]    wr_addr_in,
   output logic [DATA_WIDTH-1:0]   matrix_wr_data,
   output logic                    parse_busy,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [1:0]              err_code,
   output logic [MATRIX_IDX_W-1:0] last_idx
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_ROW, S_COL, S_DATA} state_t;

   state_t                  state, state_nxt;
   logic [2:0]              rows_q;
   logic [ADDR_IN_W-1:0]    total_q;
   logic [ADDR_IN_W-1:0]    elem_cnt;
   logic [MATRIX_IDX_W-1:0] slot_q;
   logic [TO_W-1:0]         to_cnt;

   logic dim_ok, val_ok, to_hit, last_elem;
   logic acc_row, acc_col, acc_elem, frame_end;
   logic bad_dim, bad_elem, timeout;

   assign dim_ok    = (rx_data != '0) && (rx_data <= DATA_WIDTH'(MAX_SIZE));
   assign val_ok    = (rx_data <= DATA_WIDTH'(MAX_VALUE));
   assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign last_elem = (elem_cnt == total_q - ADDR_IN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_ROW;
      else        state <= state_nxt;
   end

   // A received byte always takes priority over an expiring timeout.
   always_comb begin
      state_nxt = state;
      acc_row   = 1'b0;
      acc_col   = 1'b0;
      acc_elem  = 1'b0;
      frame_end = 1'b0;
      bad_dim   = 1'b0;
      bad_elem  = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_ROW: begin
            if (rx_valid) begin
               if (dim_ok) begin
                  acc_row   = 1'b1;
                  state_nxt = S_COL;
               end else begin
                  bad_dim = 1'b1;
               end
            end
         end
         S_COL: begin
            if (rx_valid) begin
               if (dim_ok) begin
                  acc_col   = 1'b1;
                  state_nxt = S_DATA;
               end else begin
                  bad_dim   = 1'b1;
                  state_nxt = S_ROW;
               end
            end else if (to_hit) begin
               timeout   = 1'b1;
               state_nxt = S_ROW;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               if (val_ok) begin
                  acc_elem = 1'b1;
                  if (last_elem) begin
                     frame_end = 1'b1;
                     state_nxt = S_ROW;
                  end
               end else begin
                  bad_elem  = 1'b1;
                  state_nxt = S_ROW;
               end
            end else if (to_hit) begin
               timeout   = 1'b1;
               state_nxt = S_ROW;
            end
         end
         default: state_nxt = S_ROW;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         matrix_wr_en   <= 1'b0;
         matrix_idx     <= '0;
         store_row      <= '0;
         store_col      <= '0;
         wr_addr_in     <= '0;
         matrix_wr_data <= '0;
         parse_busy     <= 1'b0;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
         err_code       <= '0;
         last_idx       <= '0;
         rows_q         <= '0;
         total_q        <= '0;
         elem_cnt       <= '0;
         slot_q         <= '0;
         to_cnt         <= '0;
      end else begin
         matrix_wr_en <= acc_elem;
         frame_done   <= frame_end;
         frame_err    <= bad_dim | bad_elem | timeout;

         if (acc_row) begin
            rows_q     <= rx_data[2:0];
            parse_busy <= 1'b1;
         end

         // Slot and dimensions are fixed once cols arrive and held for the frame.
         if (acc_col) begin
            store_row  <= rows_q;
            store_col  <= rx_data[2:0];
            matrix_idx <= slot_q;
            total_q    <= ADDR_IN_W'(rows_q) * ADDR_IN_W'(rx_data[2:0]);
            elem_cnt   <= '0;
         end

         if (acc_elem) begin
            wr_addr_in     <= elem_cnt;
            matrix_wr_data <= rx_data;
            elem_cnt       <= elem_cnt + ADDR_IN_W'(1);
         end

         if (frame_end) begin
            parse_busy <= 1'b0;
            last_idx   <= slot_q;
            slot_q     <= (slot_q == MATRIX_IDX_W'(MATRIX_NUM - 1)) ? '0
                                                                    : slot_q + MATRIX_IDX_W'(1);
         end

         if (bad_dim || bad_elem || timeout) begin
            parse_busy <= 1'b0;
            err_code   <= bad_dim ? 2'b01 : (bad_elem ? 2'b10 : 2'b11);
         end

         if (state == S_ROW || state_nxt != state || rx_valid) to_cnt <= '0;
         else                                                    to_cnt <= to_cnt + TO_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_matrix_rx_parser.sv
// Directed bench for uart_matrix_rx_parser: expected write beats and frame
// events are queued by the stimulus and checked by an independent monitor.
module tb_uart_matrix_rx_parser;

   localparam int TO = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic       matrix_wr_en;
   logic [2:0] matrix_idx;
   logic [2:0] store_row;
   logic [2:0] store_col;
   logic [4:0] wr_addr_in;
   logic [7:0] matrix_wr_data;
   logic       parse_busy;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic [2:0] last_idx;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;

   // write beat: {idx, row, col, addr, data}; event: {kind(1 done, 2 err), err_code, last_idx}
   logic [21:0] exp_q[$];
   logic [6:0]  exp_ev_q[$];
   logic [1:0]  exp_code = 2'b00;
   logic [2:0]  exp_last = 3'd0;

   uart_matrix_rx_parser #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .matrix_wr_en(matrix_wr_en), .matrix_idx(matrix_idx),
      .store_row(store_row), .store_col(store_col), .wr_addr_in(wr_addr_in),
      .matrix_wr_data(matrix_wr_data), .parse_busy(parse_busy),
      .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
      .last_idx(last_idx)
   );

   // clock/reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=hung required=finish");
      $fatal(1, "watchdog");
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done || frame_err) begin
            checks++;
            if (frame_done && frame_err) begin
               errors++;
               $display("FAIL done_err_exclusive: actual=both required=one");
            end
         end
         if (matrix_wr_en) begin
            logic [21:0] got, e;
            wr_seen++;
            checks++;
            got = {matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: actual=%h required=none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL write_beat: actual idx=%0d row=%0d col=%0d addr=%0d data=%0d required idx=%0d row=%0d col=%0d addr=%0d data=%0d",
                           got[21:19], got[18:16], got[15:13], got[12:8], got[7:0],
                           e[21:19], e[18:16], e[15:13], e[12:8], e[7:0]);
               end
            end
         end
         if (frame_done || frame_err) begin
            logic [6:0] got, e;
            got = {(frame_done ? 2'd1 : 2'd2), err_code, last_idx};
            checks++;
            if (exp_ev_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: actual=%b required=none", got);
            end else begin
               e = exp_ev_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL frame_event: actual kind=%0d code=%b last=%0d required kind=%0d code=%b last=%0d",
                           got[6:5], got[4:3], got[2:0], e[6:5], e[4:3], e[2:0]);
               end
            end
            checks++;
            if (parse_busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_at_frame_end: actual=%b required=0", parse_busy);
            end
         end
      end
   end

   // driver tasks
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = '0;
      end
   endtask

   task automatic exp_wr(input logic [2:0] idx, input logic [2:0] row, input logic [2:0] col,
                         input logic [4:0] addr, input logic [7:0] data);
      exp_q.push_back({idx, row, col, addr, data});
   endtask

   task automatic exp_done(input logic [2:0] last);
      exp_last = last;
      exp_ev_q.push_back({2'd1, exp_code, last});
   endtask

   task automatic exp_err(input logic [1:0] code);
      exp_code = code;
      exp_ev_q.push_back({2'd2, code, exp_last});
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      idle(1);
      while ((exp_q.size() != 0 || exp_ev_q.size() != 0) && n < budget) begin
         idle(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || exp_ev_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: actual pending writes=%0d events=%0d required 0 0",
                  name, exp_q.size(), exp_ev_q.size());
         exp_q.delete();
         exp_ev_q.delete();
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = '0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if ({matrix_wr_en, matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data,
           parse_busy, frame_done, frame_err, err_code, last_idx} !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs: actual wr_en=%b idx=%0d row=%0d col=%0d addr=%0d data=%0d busy=%b done=%b err=%b code=%b last=%0d required all 0",
                  matrix_wr_en, matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data,
                  parse_busy, frame_done, frame_err, err_code, last_idx);
      end
      exp_code = 2'b00;
      exp_last = 3'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // stimulus
   initial begin
      int w0;
      apply_reset();
      idle(2);

      // 2x3 frame into slot 0, then a 1x1 frame lands in slot 1
      send(8'd2); send(8'd3);
      for (int i = 0; i < 6; i++) begin
         send(8'(i + 1));
         exp_wr(3'd0, 3'd2, 3'd3, 5'(i), 8'(i + 1));
      end
      exp_done(3'd0);
      idle(1);
      check_bit("busy_after_done", parse_busy, 1'b0);
      send(8'd1); send(8'd1); send(8'd8);
      exp_wr(3'd1, 3'd1, 3'd1, 5'd0, 8'd8);
      exp_done(3'd1);
      drain("basic", 20);

      // nine 1x1 frames: slots 0..7 then wrap to 0
      apply_reset();
      idle(1);
      for (int i = 0; i < 9; i++) begin
         send(8'd1); send(8'd1); send(8'd7);
         exp_wr(3'(i % 8), 3'd1, 3'd1, 5'd0, 8'd7);
         exp_done(3'(i % 8));
      end
      drain("wrap", 20);

      // bad dimensions: rows 6, then cols 0
      send(8'd6);
      exp_err(2'b01);
      drain("bad_rows", 10);
      check_bit("busy_after_bad_rows", parse_busy, 1'b0);
      send(8'd5);
      idle(1);
      check_bit("busy_after_row", parse_busy, 1'b1);
      send(8'd0);
      exp_err(2'b01);
      drain("bad_cols", 10);

      // element too large after one good write; next frame reuses slot 1
      send(8'd2); send(8'd2); send(8'd3); send(8'd10);
      exp_wr(3'd1, 3'd2, 3'd2, 5'd0, 8'd3);
      exp_err(2'b10);
      send(8'd1); send(8'd1); send(8'd4);
      exp_wr(3'd1, 3'd1, 3'd1, 5'd0, 8'd4);
      exp_done(3'd1);
      drain("bad_value", 20);

      // timeout inside a 3x3 frame, slot 2
      send(8'd3); send(8'd3); send(8'd4);
      exp_wr(3'd2, 3'd3, 3'd3, 5'd0, 8'd4);
      idle(10);
      check_bit("busy_mid_frame", parse_busy, 1'b1);
      exp_err(2'b11);
      drain("timeout", TO + 20);
      idle(5);
      checks++;
      if (err_code !== 2'b11) begin
         errors++;
         $display("FAIL err_code_held: actual=%b required=11", err_code);
      end

      // back-to-back 5x5 frame interrupted by reset after two elements
      send(8'd5); send(8'd5); send(8'd1); send(8'd2);
      exp_wr(3'd2, 3'd5, 3'd5, 5'd0, 8'd1);
      exp_wr(3'd2, 3'd5, 3'd5, 5'd1, 8'd2);
      drain("pre_reset", 10);
      apply_reset();
      w0 = wr_seen;
      idle(20);
      checks++;
      if (wr_seen != w0) begin
         errors++;
         $display("FAIL no_write_after_reset: actual=%0d writes required=0", wr_seen - w0);
      end
      send(8'd1); send(8'd1); send(8'd3);
      exp_wr(3'd0, 3'd1, 3'd1, 5'd0, 8'd3);
      exp_done(3'd0);
      drain("post_reset", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
